minsum_tracker: RTL
===================

MINSUM_TRACKER -- requirements
Module: minsum_tracker

Interface
REQ-001 Parameter DATA_W, default 8, magnitude width in bits (unsigned).
REQ-002 Parameter IDX_W, default 8, width of beat index and degree count.
REQ-003 Parameter MAX_DEG, default 32, maximum beats per frame; SHALL satisfy 2 <= MAX_DEG <= 2**IDX_W.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 in_data  input  DATA_W  unsigned magnitude of beat.
REQ-009 in_last  input  1  final beat of frame.
REQ-010 out_valid  output  1  frame result held.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out_min1  output  DATA_W  smallest magnitude of frame.
REQ-013 out_min2  output  DATA_W  second-smallest magnitude of frame.
REQ-014 out_idx1  output  IDX_W  0-based beat position of out_min1.
REQ-015 out_deg  output  IDX_W  number of beats accepted in frame, minus one.
REQ-016 out_ovf  output  1  frame exceeded MAX_DEG beats.

Function
REQ-017 Beat accepted iff in_valid && in_ready on a rising edge.
REQ-018 Two states: ACC (accumulating, in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-019 ACC -> HOLD on accepted beat with in_last=1; HOLD -> ACC on out_valid && out_ready; no other transitions.
REQ-020 Latency: out_valid SHALL be 1 in the cycle immediately after the last beat is accepted; one bubble cycle (in_ready=0) minimum between frames.
REQ-021 At frame start running min1, min2 SHALL be all-ones, running index counter 0, ovf 0.
REQ-022 Per accepted beat x at position cnt: if x < min1 then min2<=min1, min1<=x, idx1<=cnt; else if x < min2 then min2<=x; else no change.
REQ-023 Ties: strict comparison; equal value never replaces min1, so earliest position wins idx1; x == min1 < min2 sets min2 to x.
REQ-024 cnt increments per accepted beat; saturates at MAX_DEG-1; beat accepted while cnt == MAX_DEG-1 and in_last=0 SHALL set sticky ovf for the frame.
REQ-025 Beats after overflow still update min1/min2; idx1 records saturated cnt.
REQ-026 Single-beat frame: out_min2 SHALL be all-ones, out_idx1 0, out_deg 0.
REQ-027 out_min1, out_min2, out_idx1, out_deg, out_ovf SHALL be registered and stable throughout HOLD.
REQ-028 On HOLD->ACC handoff running state SHALL be reinitialised per REQ-021 in the same edge; in_valid during HOLD is ignored.
REQ-029 Output ports SHALL hold last values when out_valid=0 (no consumer meaning).

Reset
REQ-030 rst=1 SHALL immediately force state ACC, out_valid 0, in_ready 1 after release, min1/min2 all-ones, idx1 0, cnt 0, out_deg 0, out_ovf 0, out_min1/out_min2 all-ones.
REQ-031 Reset mid-frame or during HOLD SHALL discard the partial/pending result; no out_valid until a complete new frame.

Verification
REQ-032 Frame 7,3,9,3,5 (last on 5) -> next cycle out_valid=1, min1=3, min2=3, idx1=1, deg=4, ovf=0.
REQ-033 Single beat 200 with in_last -> min1=200, min2=255, idx1=0, deg=0.
REQ-034 out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, outputs stable, no beat consumed; then out_ready=1 -> ACC, next frame starts fresh.
REQ-035 MAX_DEG=4, frame 9,8,7,6,1 (last on 1) -> min1=1, min2=6, idx1=3, deg=3, ovf=1.
REQ-036 Assert rst after 3 beats of a frame, release, send 4,2 -> min1=2, min2=4, idx1=1, deg=1.
REQ-037 Descending 10,9,...,1 then ascending 1..10 in back-to-back frames with random in_valid gaps -> min1=1, min2=2, idx1=9 then 0; compare against reference model each frame.

Source files
------------

// File: rtl/minsum_tracker.sv
// Streaming min/second-min tracker. It accumulates one frame of magnitudes,
// then holds the frame result until the consumer takes it.
module minsum_tracker #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned IDX_W   = 8,
    parameter int unsigned MAX_DEG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min1,
    output logic [DATA_W-1:0] out_min2,
    output logic [IDX_W-1:0]  out_idx1,
    output logic [IDX_W-1:0]  out_deg,
    output logic              out_ovf
);

    localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(MAX_DEG - 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t              state_q;
    logic                in_ready_q, out_valid_q;
    logic [DATA_W-1:0]   min1_q, min2_q, min1_d, min2_d;
    logic [IDX_W-1:0]    idx1_q, idx1_d, cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   out_min1_q, out_min2_q;
    logic [IDX_W-1:0]    out_idx1_q, out_deg_q;
    logic                out_ovf_q;
    logic                accept;

    assign accept = in_valid && in_ready_q;

    // Strict compares: a tie with min1 only ever lands in min2.
    always_comb begin
        min1_d = min1_q;
        min2_d = min2_q;
        idx1_d = idx1_q;
        if (in_data < min1_q) begin
            min2_d = min1_q;
            min1_d = in_data;
            idx1_d = cnt_q;
        end else if (in_data < min2_q) begin
            min2_d = in_data;
        end
        ovf_d = ovf_q | ((cnt_q == CNT_MAX) && !in_last);
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            min1_q      <= '1;
            min2_q      <= '1;
            idx1_q      <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_min1_q  <= '1;
            out_min2_q  <= '1;
            out_idx1_q  <= '0;
            out_deg_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        if (in_last) begin
                            out_min1_q  <= min1_d;
                            out_min2_q  <= min2_d;
                            out_idx1_q  <= idx1_d;
                            out_deg_q   <= cnt_q;
                            out_ovf_q   <= ovf_d;
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            min1_q      <= '1;
                            min2_q      <= '1;
                            idx1_q      <= '0;
                            cnt_q       <= '0;
                            ovf_q       <= 1'b0;
                        end else begin
                            min1_q <= min1_d;
                            min2_q <= min2_d;
                            idx1_q <= idx1_d;
                            cnt_q  <= cnt_d;
                            ovf_q  <= ovf_d;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= ACC;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        min1_q      <= '1;
                        min2_q      <= '1;
                        idx1_q      <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_min1  = out_min1_q;
    assign out_min2  = out_min2_q;
    assign out_idx1  = out_idx1_q;
    assign out_deg   = out_deg_q;
    assign out_ovf   = out_ovf_q;

endmodule
